// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
    typedef enum logic {RUN, MEM_WAIT} hz_state_t;
    localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline-side hazard inputs and sequencing/perf outputs
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       AddrA_ID;
    logic [4:0]       AddrB_ID;
    logic [4:0]       Rd_EX;
    logic             MemRead_EX;
    logic             BrTaken_EX;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PC_en;
    logic             IF_ID_en;
    logic             ID_EX_en;
    logic             EX_MEM_en;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             MEM_WB_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;
    modport master (
        output AddrA_ID, AddrB_ID, Rd_EX, MemRead_EX, BrTaken_EX, dmem_req, dmem_ready,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble,
        input  stall_cycles, flush_count, mem_timeout
    );
    modport slave (
        input  AddrA_ID, AddrB_ID, Rd_EX, MemRead_EX, BrTaken_EX, dmem_req, dmem_ready,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble,
        output stall_cycles, flush_count, mem_timeout
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    // increment on request unless already saturated
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (inc && !(&q)) q <= q + W'(1);
    end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use / taken-branch / dmem-wait sequencing with perf counters
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int WAIT_TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset_n,
    hazard_controller_if.slave hz
);
    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             r_timeout;
    logic             w_load_use;
    logic             w_mem_stall;
    logic             w_freeze;
    logic             w_branch;
    logic             w_lu_stall;

    assign w_load_use  = hz.MemRead_EX && (hz.Rd_EX != XZR) &&
                         (hz.AddrA_ID == hz.Rd_EX || hz.AddrB_ID == hz.Rd_EX);
    assign w_mem_stall = hz.dmem_req && !hz.dmem_ready;
    // whole pipe freezes on a new miss in RUN, or while still waiting in MEM_WAIT
    assign w_freeze    = (r_state == RUN) ? w_mem_stall : !hz.dmem_ready;
    // branch beats load-use; neither acts while frozen since EX is held
    assign w_branch    = !w_freeze && hz.BrTaken_EX;
    assign w_lu_stall  = !w_freeze && !hz.BrTaken_EX && w_load_use;
    assign w_wait_nxt  = (r_state == RUN) ? CNT_W'(1) : (&r_wait_cnt ? r_wait_cnt : r_wait_cnt + CNT_W'(1));

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RUN;
        else r_state <= w_state_nxt;
    end

    // next state: sit in MEM_WAIT exactly as long as memory is outstanding
    always_comb begin
        w_state_nxt = w_freeze ? MEM_WAIT : RUN;
    end

    // Mealy strobes, all forced inactive while reset is asserted
    always_comb begin
        hz.PC_en         = reset_n && !w_freeze && !w_lu_stall;
        hz.IF_ID_en      = reset_n && !w_freeze && !w_lu_stall;
        hz.ID_EX_en      = reset_n && !w_freeze;
        hz.EX_MEM_en     = reset_n && !w_freeze;
        hz.IF_ID_flush   = reset_n && w_branch;
        hz.ID_EX_bubble  = reset_n && (w_branch || w_lu_stall);
        hz.MEM_WB_bubble = reset_n && w_freeze;
    end

    // wait length tracking and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_freeze) begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt >= CNT_W'(WAIT_TIMEOUT)) r_timeout <= 1'b1;
        end
    end

    assign hz.mem_timeout = r_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (!hz.PC_en),
        .q       (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_branch),
        .q       (hz.flush_count)
    );
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed + random stimulus against a cycle-level behavioural model
module tb_hazard_controller;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] a = '0, b = '0, rd = '0;
    logic       mr = 1'b0, bt = 1'b0, req = 1'b0, rdy = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_wait = 0;
    int m_wlen = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_to = 0;
    bit m_to_s = 0;

    hazard_controller_if #(.CNT_W(16)) hz();
    hazard_controller_if #(.CNT_W(2))  hs();

    assign hz.AddrA_ID = a;  assign hs.AddrA_ID = a;
    assign hz.AddrB_ID = b;  assign hs.AddrB_ID = b;
    assign hz.Rd_EX = rd;    assign hs.Rd_EX = rd;
    assign hz.MemRead_EX = mr; assign hs.MemRead_EX = mr;
    assign hz.BrTaken_EX = bt; assign hs.BrTaken_EX = bt;
    assign hz.dmem_req = req;  assign hs.dmem_req = req;
    assign hz.dmem_ready = rdy; assign hs.dmem_ready = rdy;

    hazard_controller #(.CNT_W(16), .WAIT_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .hz(hz)
    );
    hazard_controller #(.CNT_W(2), .WAIT_TIMEOUT(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .hz(hs)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(int v, int mx);
        return v > mx ? mx : v;
    endfunction

    function automatic logic [31:0] strobes_l();
        return 32'({hz.PC_en, hz.IF_ID_en, hz.ID_EX_en, hz.EX_MEM_en, hz.IF_ID_flush, hz.ID_EX_bubble, hz.MEM_WB_bubble});
    endfunction

    function automatic logic [31:0] strobes_s();
        return 32'({hs.PC_en, hs.IF_ID_en, hs.ID_EX_en, hs.EX_MEM_en, hs.IF_ID_flush, hs.ID_EX_bubble, hs.MEM_WB_bubble});
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wlen = 0; m_stall = 0; m_flush = 0; m_to = 0; m_to_s = 0;
    endtask

    task automatic check_counters(string tag);
        check({tag, "/stall"},   32'(hz.stall_cycles), 32'(sat(m_stall, 65535)));
        check({tag, "/stall_s"}, 32'(hs.stall_cycles), 32'(sat(m_stall, 3)));
        check({tag, "/flush"},   32'(hz.flush_count),  32'(sat(m_flush, 65535)));
        check({tag, "/flush_s"}, 32'(hs.flush_count),  32'(sat(m_flush, 3)));
        check({tag, "/tmo"},     32'(hz.mem_timeout),  32'(m_to));
        check({tag, "/tmo_s"},   32'(hs.mem_timeout),  32'(m_to_s));
    endtask

    task automatic drive(logic [4:0] ia, logic [4:0] ib, logic [4:0] ird, logic imr, logic ibt, logic ireq, logic irdy);
        a = ia; b = ib; rd = ird; mr = imr; bt = ibt; req = ireq; rdy = irdy;
    endtask

    // one clock: check strobes mid-cycle, advance model at the edge, check registered state after it
    task automatic cycle(string tag);
        bit lu, fr, br, luh;
        logic [6:0] e;
        #1;
        lu  = mr && rd != 5'd31 && (a == rd || b == rd);
        fr  = m_wait ? !rdy : (req && !rdy);
        br  = !fr && bt;
        luh = !fr && !bt && lu;
        e   = {!fr && !luh, !fr && !luh, !fr, !fr, br, br || luh, fr};
        check({tag, "/strobes"},   strobes_l(), 32'(e));
        check({tag, "/strobes_s"}, strobes_s(), 32'(e));
        @(posedge clk);
        if (fr) begin
            m_wlen = m_wait ? m_wlen + 1 : 1;
            if (m_wlen >= 4) m_to = 1;
            if (m_wlen >= 3) m_to_s = 1;
        end
        m_wait = fr;
        if (fr || luh) m_stall++;
        if (br) m_flush++;
        #1;
        check_counters(tag);
        @(negedge clk);
    endtask

    initial begin
        #2;
        check("reset/strobes", strobes_l(), 32'd0);
        check_counters("reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        drive(3, 0, 3, 1, 0, 0, 1); cycle("load_use");
        drive(3, 0, 3, 0, 0, 0, 1); cycle("lu_release");
        drive(0, 31, 31, 1, 0, 0, 1); cycle("xzr");
        drive(5, 7, 5, 1, 1, 0, 1); cycle("br_vs_lu");
        drive(0, 0, 0, 0, 0, 1, 0);
        repeat (3) cycle("mem_wait");
        drive(0, 0, 0, 0, 0, 1, 1); cycle("mem_release");
        drive(0, 0, 0, 0, 0, 0, 1); cycle("run_after");
        drive(0, 0, 0, 0, 0, 1, 0);
        repeat (6) cycle("timeout");
        drive(2, 2, 2, 1, 1, 0, 1); cycle("tmo_release");
        drive(0, 0, 0, 0, 0, 0, 1); cycle("tmo_sticky");
        drive(0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle("pre_areset");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("areset/strobes",   strobes_l(), 32'd0);
        check("areset/strobes_s", strobes_s(), 32'd0);
        check_counters("areset");
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1); cycle("post_areset");
        drive(1, 0, 1, 1, 0, 0, 1);
        repeat (5) cycle("sat");
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), r, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) < 3);
            cycle("random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
